// File: rtl/bnn_os_psum_array_if.sv
// ---------------------------------------------------------------------------
// bnn_os_psum_array_if
// Groups the stream/control inputs and the pop-side outputs of
// bnn_os_psum_array.
//   master : drives data_in, load_weight_in, in_valid_in, clear_in, pop_in,
//            sum_ready_in; observes sum_out, sum_ch_out, sum_valid_out,
//            busy_out, weight_full_out
//   slave  : the accumulator array itself (mirror of master)
// ---------------------------------------------------------------------------
interface bnn_os_psum_array_if #(
   parameter int ACT_W          = 9,
   parameter int OUT_ROW_LENGTH = 4,
   parameter int O_CH           = 64,
   parameter int CH_IDX_W       = $clog2(O_CH)
);
   logic [ACT_W-1:0]          data_in;
   logic                      load_weight_in;
   logic                      in_valid_in;
   logic                      clear_in;
   logic                      pop_in;
   logic                      sum_ready_in;
   logic [OUT_ROW_LENGTH-1:0] sum_out;
   logic [CH_IDX_W-1:0]       sum_ch_out;
   logic                      sum_valid_out;
   logic                      busy_out;
   logic                      weight_full_out;

   modport master (
      output data_in, load_weight_in, in_valid_in, clear_in, pop_in, sum_ready_in,
      input  sum_out, sum_ch_out, sum_valid_out, busy_out, weight_full_out
   );

   modport slave (
      input  data_in, load_weight_in, in_valid_in, clear_in, pop_in, sum_ready_in,
      output sum_out, sum_ch_out, sum_valid_out, busy_out, weight_full_out
   );
endinterface

// File: rtl/bnn_os_psum_array.sv
// ---------------------------------------------------------------------------
// bnn_os_psum_array
// Binary (XNOR) weight-stationary / output-stationary partial-sum array.
// O_CH channels each hold one stationary ACT_W-bit weight. Activations enter
// channel 0 directly and reach channel c through c skew registers. Each valid
// activation adds 2*popcount(xnor)-ACT_W into a rotating row of
// OUT_ROW_LENGTH psums per channel. A pop request drains the skew pipe and
// then streams each channel's psum sign bits over a valid/ready handshake.
//
// Ports:
//   clk_in  : clock, rising edge
//   rst_in  : synchronous active-high reset
//   bus     : bnn_os_psum_array_if.slave (stream inputs, pop outputs)
//
// Build option:
//   BNN_PSUM_SATURATE_EN defined   -> psum accumulation clamps at the
//                                     WIDTH-bit signed limits
//   BNN_PSUM_SATURATE_EN undefined -> psum accumulation wraps around
// ---------------------------------------------------------------------------
module bnn_os_psum_array #(
   parameter int ACT_W          = 9,
   parameter int WIDTH          = 14,
   parameter int OUT_ROW_LENGTH = 4,
   parameter int O_CH           = 64,
   parameter int CH_IDX_W       = $clog2(O_CH)
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   bnn_os_psum_array_if.slave        bus
);

   localparam int L     = OUT_ROW_LENGTH;
   localparam int CNT_W = $clog2(O_CH + 1);
   localparam logic signed [WIDTH-1:0] PSUM_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] PSUM_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_POP} state_t;

   // bipolar XNOR-popcount contribution, sign-extended to WIDTH
   function automatic logic signed [WIDTH-1:0] f_contrib(input logic [ACT_W-1:0] act,
                                                         input logic [ACT_W-1:0] wgt);
      logic [ACT_W-1:0] x;
      int               pc;
      int               s;
      x  = ~(act ^ wgt);
      pc = 0;
      for (int i = 0; i < ACT_W; i++) pc = pc + int'(x[i]);
      s  = 2 * pc - ACT_W;
      f_contrib = s[WIDTH-1:0];
   endfunction

   function automatic logic signed [WIDTH-1:0] f_sat_add(input logic signed [WIDTH-1:0] a,
                                                         input logic signed [WIDTH-1:0] b);
      logic signed [WIDTH:0] s;
      s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
`ifdef BNN_PSUM_SATURATE_EN
      // top two bits disagree only on signed overflow
      if (s[WIDTH] != s[WIDTH-1]) f_sat_add = s[WIDTH] ? PSUM_MIN : PSUM_MAX;
      else                        f_sat_add = s[WIDTH-1:0];
`else
      f_sat_add = s[WIDTH-1:0];
`endif
   endfunction

   state_t                   r_state;
   logic [CH_IDX_W-1:0]      r_ch;
   logic                     r_busy;
   logic                     r_sum_valid;

   logic [ACT_W-1:0]         r_w        [O_CH];
   logic [ACT_W-1:0]         r_shadow   [O_CH];
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_dirty;
   logic [ACT_W-1:0]         r_pipe_act [O_CH-1];
   logic [O_CH-2:0]          r_pipe_vld;
   logic signed [WIDTH-1:0]  r_psum     [O_CH][L];

   logic                     w_idle;
   logic                     w_vld0;
   logic [ACT_W-1:0]         w_act0;
   logic                     w_pipe_busy;
   logic [ACT_W-1:0]         w_ch_act   [O_CH];
   logic [O_CH-1:0]          w_ch_vld;
   logic [L-1:0]             w_sum;

   // Activations are only admitted in IDLE and lose to a weight load; in
   // DRAIN/POP a bubble is injected so the pipe empties.
   always_comb begin
      w_idle      = (r_state == S_IDLE);
      w_vld0      = w_idle & bus.in_valid_in & ~bus.load_weight_in & ~bus.clear_in;
      w_act0      = w_vld0 ? bus.data_in : '0;
      w_pipe_busy = |r_pipe_vld;
      w_ch_act[0] = w_act0;
      w_ch_vld[0] = w_vld0;
      for (int c = 1; c < O_CH; c++) begin
         w_ch_act[c] = r_pipe_act[c-1];
         w_ch_vld[c] = r_pipe_vld[c-1];
      end
   end

   always_comb begin
      w_sum = '0;
      if (r_sum_valid)
         for (int k = 0; k < L; k++) w_sum[L-1-k] = r_psum[r_ch][k][WIDTH-1];
   end

   // Skew pipe, psum rows, and weight shadow/commit
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int c = 0; c < O_CH; c++) begin
            r_w[c]      <= '0;
            r_shadow[c] <= '0;
            for (int k = 0; k < L; k++) r_psum[c][k] <= '0;
         end
         for (int c = 0; c < O_CH-1; c++) r_pipe_act[c] <= '0;
         r_pipe_vld <= '0;
         r_cnt      <= '0;
         r_dirty    <= 1'b0;
      end else if (bus.clear_in) begin
         for (int c = 0; c < O_CH; c++)
            for (int k = 0; k < L; k++) r_psum[c][k] <= '0;
         for (int c = 0; c < O_CH-1; c++) r_pipe_act[c] <= '0;
         r_pipe_vld <= '0;
      end else begin
         r_pipe_act[0] <= w_act0;
         r_pipe_vld[0] <= w_vld0;
         for (int c = 1; c < O_CH-1; c++) begin
            r_pipe_act[c] <= r_pipe_act[c-1];
            r_pipe_vld[c] <= r_pipe_vld[c-1];
         end

         // rotate the row: the oldest entry re-enters slot 0 with the new term
         for (int c = 0; c < O_CH; c++) begin
            if (w_ch_vld[c]) begin
               r_psum[c][0] <= f_sat_add(r_psum[c][L-1], f_contrib(w_ch_act[c], r_w[c]));
               for (int k = 1; k < L; k++) r_psum[c][k] <= r_psum[c][k-1];
            end
         end

         if (bus.load_weight_in && w_idle) begin
            r_shadow[0] <= bus.data_in;
            for (int c = 1; c < O_CH; c++) r_shadow[c] <= r_shadow[c-1];
            if (r_cnt != CNT_W'(O_CH)) r_cnt <= r_cnt + CNT_W'(1);
            r_dirty <= 1'b1;
         end else if (!bus.load_weight_in && w_idle && !w_pipe_busy) begin
            // weights only swap once in-flight activations have used the old set
            if (r_dirty) r_w <= r_shadow;
            r_cnt   <= '0;
            r_dirty <= 1'b0;
         end
      end
   end

   // Control FSM: IDLE -> DRAIN -> POP -> IDLE
   always_ff @(posedge clk_in) begin
      if (rst_in || bus.clear_in) begin
         r_state     <= S_IDLE;
         r_ch        <= '0;
         r_busy      <= 1'b0;
         r_sum_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.pop_in) begin
                  r_state <= S_DRAIN;
                  r_busy  <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (!w_pipe_busy) begin
                  r_state     <= S_POP;
                  r_ch        <= '0;
                  r_sum_valid <= 1'b1;
               end
            end
            S_POP: begin
               if (bus.sum_ready_in) begin
                  if (r_ch == CH_IDX_W'(O_CH-1)) begin
                     r_state     <= S_IDLE;
                     r_ch        <= '0;
                     r_busy      <= 1'b0;
                     r_sum_valid <= 1'b0;
                  end else begin
                     r_ch <= r_ch + CH_IDX_W'(1);
                  end
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_ch        <= '0;
               r_busy      <= 1'b0;
               r_sum_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sum_out         = w_sum;
   assign bus.sum_ch_out      = r_ch;
   assign bus.sum_valid_out   = r_sum_valid;
   assign bus.busy_out        = r_busy;
   assign bus.weight_full_out = (r_cnt == CNT_W'(O_CH));

endmodule

// File: tb/tb_bnn_os_psum_array.sv
// ---------------------------------------------------------------------------
// tb_bnn_os_psum_array
// Directed bench for bnn_os_psum_array with O_CH=4, L=2, ACT_W=9, WIDTH=6.
// The stimulus process queues the expected {channel, sign bits} of every pop
// beat; an independent monitor compares each presented beat against the
// queue head. Honours BNN_PSUM_SATURATE_EN for the overflow expectation.
// ---------------------------------------------------------------------------
module tb_bnn_os_psum_array;
   localparam int ACT_W    = 9;
   localparam int WIDTH    = 6;
   localparam int L        = 2;
   localparam int O_CH     = 4;
   localparam int CH_IDX_W = 2;

`ifdef BNN_PSUM_SATURATE_EN
   localparam logic [L-1:0] OVF_SUM = 2'b00;   // both positions clamp to +31
`else
   localparam logic [L-1:0] OVF_SUM = 2'b11;   // both positions wrap to -28
`endif

   typedef struct packed {
      logic [CH_IDX_W-1:0] ch;
      logic [L-1:0]        sum;
   } beat_t;

   logic  clk = 1'b0;
   logic  rst;
   beat_t sb_q[$];
   int    n_chk  = 0;
   int    n_fail = 0;

   always #5 clk = ~clk;

   bnn_os_psum_array_if #(.ACT_W(ACT_W), .OUT_ROW_LENGTH(L), .O_CH(O_CH),
                          .CH_IDX_W(CH_IDX_W)) bus ();

   bnn_os_psum_array #(.ACT_W(ACT_W), .WIDTH(WIDTH), .OUT_ROW_LENGTH(L),
                       .O_CH(O_CH), .CH_IDX_W(CH_IDX_W)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int ch, input logic [L-1:0] s);
      beat_t b;
      b.ch  = CH_IDX_W'(ch);
      b.sum = s;
      sb_q.push_back(b);
   endtask

   task automatic push_all(input logic [L-1:0] s);
      for (int i = 0; i < O_CH; i++) push(i, s);
   endtask

   task automatic do_pop();
      bus.pop_in = 1'b1;
      tick();
      bus.pop_in = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (bus.busy_out && n < 40) begin
         tick();
         n++;
      end
      check({name, "_idle_timeout"}, 32'(bus.busy_out), 0);
   endtask

   task automatic wait_beat(input int ch, input string name);
      int n;
      n = 0;
      while (!(bus.sum_valid_out && 32'(bus.sum_ch_out) == ch) && n < 40) begin
         tick();
         n++;
      end
      check(name, 32'(bus.sum_ch_out), ch);
   endtask

   // Monitor: every presented beat must match the queue head
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.sum_valid_out) begin
            if (sb_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_beat: got ch %0d sum %b, nothing expected",
                        bus.sum_ch_out, bus.sum_out);
            end else begin
               check("beat_ch", 32'(bus.sum_ch_out), 32'(sb_q[0].ch));
               check("beat_sum", 32'(bus.sum_out), 32'(sb_q[0].sum));
               if (bus.sum_ready_in) void'(sb_q.pop_front());
            end
         end else begin
            check("sum_out_zero_when_invalid", 32'(bus.sum_out), 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                = 1'b1;
      bus.data_in        = '0;
      bus.load_weight_in = 1'b0;
      bus.in_valid_in    = 1'b0;
      bus.clear_in       = 1'b0;
      bus.pop_in         = 1'b0;
      bus.sum_ready_in   = 1'b1;
      tick();
      tick();
      check("rst_valid", 32'(bus.sum_valid_out), 0);
      check("rst_busy",  32'(bus.busy_out), 0);
      check("rst_full",  32'(bus.weight_full_out), 0);
      check("rst_sum",   32'(bus.sum_out), 0);
      check("rst_ch",    32'(bus.sum_ch_out), 0);
      rst = 1'b0;

      // Load four all-ones weights and commit
      bus.load_weight_in = 1'b1;
      bus.data_in        = 9'h1FF;
      repeat (3) tick();
      check("full_after_3", 32'(bus.weight_full_out), 0);
      tick();
      check("full_after_4", 32'(bus.weight_full_out), 1);
      bus.load_weight_in = 1'b0;
      bus.data_in        = '0;
      tick();
      check("full_after_commit", 32'(bus.weight_full_out), 0);

      // Compute: +9 then -9 -> psum[0]=-9, psum[1]=+9 -> 2'b10
      bus.clear_in = 1'b1;
      tick();
      bus.clear_in    = 1'b0;
      bus.in_valid_in = 1'b1;
      bus.data_in     = 9'h1FF;
      tick();
      bus.data_in = 9'h000;
      tick();
      bus.in_valid_in = 1'b0;
      push_all(2'b10);
      do_pop();
      check("drain1_busy",  32'(bus.busy_out), 1);
      check("drain1_valid", 32'(bus.sum_valid_out), 0);
      tick();
      check("drain2_valid", 32'(bus.sum_valid_out), 0);
      tick();
      check("drain3_valid", 32'(bus.sum_valid_out), 0);
      tick();
      check("pop_start_valid", 32'(bus.sum_valid_out), 1);
      check("pop_start_ch",    32'(bus.sum_ch_out), 0);
      repeat (3) tick();
      check("busy_before_last", 32'(bus.busy_out), 1);
      tick();
      check("busy_after_last",  32'(bus.busy_out), 0);
      check("valid_after_last", 32'(bus.sum_valid_out), 0);

      // Backpressure at ch=1 (psums unchanged by the previous pop)
      push_all(2'b10);
      do_pop();
      wait_beat(1, "bp_reach_ch1");
      bus.sum_ready_in = 1'b0;
      repeat (5) begin
         tick();
         check("bp_hold_ch",    32'(bus.sum_ch_out), 1);
         check("bp_hold_sum",   32'(bus.sum_out), 32'(2'b10));
         check("bp_hold_valid", 32'(bus.sum_valid_out), 1);
      end
      bus.sum_ready_in = 1'b1;
      tick();
      check("bp_advance_ch", 32'(bus.sum_ch_out), 2);
      wait_idle("bp");

      // Overflow: eight +9 contributions -> +36 per position
      bus.clear_in = 1'b1;
      tick();
      bus.clear_in    = 1'b0;
      bus.in_valid_in = 1'b1;
      bus.data_in     = 9'h1FF;
      repeat (8) tick();
      bus.in_valid_in = 1'b0;
      bus.data_in     = '0;
      push_all(OVF_SUM);
      do_pop();
      wait_idle("ovf");

      // Precedence: load wins over a simultaneous valid activation
      bus.clear_in = 1'b1;
      tick();
      bus.clear_in       = 1'b0;
      bus.load_weight_in = 1'b1;
      bus.in_valid_in    = 1'b1;
      bus.data_in        = 9'h000;
      tick();
      bus.load_weight_in = 1'b0;
      bus.in_valid_in    = 1'b0;
      tick();
      push_all(2'b00);
      do_pop();
      wait_idle("prec");

      // Weights now ch0=000, ch1..3=1FF. Activation 000: ch0 +9, others -9.
      bus.in_valid_in = 1'b1;
      bus.data_in     = 9'h000;
      tick();
      bus.in_valid_in = 1'b0;
      push(0, 2'b00);
      push(1, 2'b10);
      push(2, 2'b10);
      do_pop();
      wait_beat(2, "abort_reach_ch2");
      bus.sum_ready_in = 1'b0;
      bus.clear_in     = 1'b1;
      tick();
      bus.clear_in     = 1'b0;
      bus.sum_ready_in = 1'b1;
      check("abort_valid", 32'(bus.sum_valid_out), 0);
      check("abort_busy",  32'(bus.busy_out), 0);
      check("abort_sum",   32'(bus.sum_out), 0);
      check("abort_leftover", sb_q.size(), 1);
      sb_q.delete();
      push_all(2'b00);
      do_pop();
      wait_idle("after_clear");

      // Reset during DRAIN
      bus.in_valid_in = 1'b1;
      bus.data_in     = 9'h1FF;
      tick();
      bus.in_valid_in = 1'b0;
      do_pop();
      check("rst_pre_busy", 32'(bus.busy_out), 1);
      rst = 1'b1;
      tick();
      check("rst2_busy",  32'(bus.busy_out), 0);
      check("rst2_valid", 32'(bus.sum_valid_out), 0);
      check("rst2_sum",   32'(bus.sum_out), 0);
      check("rst2_ch",    32'(bus.sum_ch_out), 0);
      check("rst2_full",  32'(bus.weight_full_out), 0);
      rst = 1'b0;
      // zero weights: activation 1FF gives -9 everywhere -> 2'b10
      bus.in_valid_in = 1'b1;
      bus.data_in     = 9'h1FF;
      tick();
      bus.in_valid_in = 1'b0;
      bus.data_in     = '0;
      push_all(2'b10);
      do_pop();
      wait_idle("post_rst");

      tick();
      check("scoreboard_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
